// File: rtl/memory_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module : memory_arbiter_rr_if
// Brief  : CPU request channels and shared RAM port of memory_arbiter_rr.
// Rev    : 1.0
// ============================================================================
interface memory_arbiter_rr_if #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*ADDR_W-1:0] iaddr;
  logic [CPUS*ADDR_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS*WORD_W-1:0] dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  logic [1:0]             ramstate;
  logic                   err;
  logic [15:0]            done_cnt;

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           err, done_cnt
  );

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           err, done_cnt
  );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module : memory_arbiter_rr
// Brief  : Round-robin arbiter of per-CPU I/D channels onto one RAM port.
// Rev    : 1.0
// ============================================================================
module memory_arbiter_rr #(
  parameter int CPUS    = 2,
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  wire logic          CLK,
  input  wire logic          RST,
  memory_arbiter_rr_if.slave bus
);
  localparam int               CPU_W      = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int               TMO_W      = $clog2(TIMEOUT);
  localparam logic [CPU_W-1:0] CPU_ONE    = CPU_W'(1);
  localparam logic [CPU_W-1:0] CPU_LAST   = CPU_W'(CPUS - 1);
  localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [1:0]       RAM_ACCESS = 2'd2;
  localparam logic [1:0]       RAM_ERROR  = 2'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CPU_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CPU_W-1:0] gnt_cpu_q, gnt_cpu_d;
  logic             gnt_dch_q, gnt_dch_d;
  logic             gnt_wr_q, gnt_wr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [15:0]      done_q, done_d;

  logic [ADDR_W-1:0] iaddr_a  [CPUS];
  logic [ADDR_W-1:0] daddr_a  [CPUS];
  logic [WORD_W-1:0] dstore_a [CPUS];

  for (genvar k = 0; k < CPUS; k++) begin : g_unpack
    assign iaddr_a[k]  = bus.iaddr[k*ADDR_W +: ADDR_W];
    assign daddr_a[k]  = bus.daddr[k*ADDR_W +: ADDR_W];
    assign dstore_a[k] = bus.dstore[k*WORD_W +: WORD_W];
  end

  logic             arb_found;
  logic [CPU_W-1:0] arb_cpu;
  logic [CPU_W-1:0] cand;
  logic             arb_dch;
  logic             arb_wr;

  // First requesting CPU at or after rr_ptr wins; its D-channel beats its I-channel.
  always_comb begin
    arb_found = 1'b0;
    arb_cpu   = '0;
    arb_dch   = 1'b0;
    arb_wr    = 1'b0;
    cand      = '0;
    for (int i = 0; i < CPUS; i++) begin
      cand = CPU_W'((int'(rr_ptr_q) + i) % CPUS);
      if (!arb_found) begin
        if (bus.dREN[cand] || bus.dWEN[cand]) begin
          arb_found = 1'b1;
          arb_cpu   = cand;
          arb_dch   = 1'b1;
          arb_wr    = bus.dWEN[cand];
        end else if (bus.iREN[cand]) begin
          arb_found = 1'b1;
          arb_cpu   = cand;
        end
      end
    end
  end

  logic             req_ok;
  logic [CPU_W-1:0] rr_next;

  // A change of request type on the granted channel counts as a withdrawal.
  always_comb begin
    req_ok = 1'b0;
    if (gnt_dch_q) begin
      req_ok = gnt_wr_q ? bus.dWEN[gnt_cpu_q]
                        : (bus.dREN[gnt_cpu_q] && !bus.dWEN[gnt_cpu_q]);
    end else begin
      req_ok = bus.iREN[gnt_cpu_q];
    end
    rr_next = (gnt_cpu_q == CPU_LAST) ? '0 : gnt_cpu_q + CPU_ONE;
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_cpu_d = gnt_cpu_q;
    gnt_dch_d = gnt_dch_q;
    gnt_wr_d  = gnt_wr_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    done_d    = done_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d   = GRANT;
          gnt_cpu_d = arb_cpu;
          gnt_dch_d = arb_dch;
          gnt_wr_d  = arb_wr;
          tmo_d     = '0;
        end
      end
      GRANT: begin
        if (bus.ramstate == RAM_ACCESS) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
          done_d   = done_q + 16'd1;
        end else if (bus.ramstate == RAM_ERROR) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
          err_d    = 1'b1;
        end else if (!req_ok) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
          err_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
    endcase
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = '1;
    bus.dwait    = '1;
    if (state_q == GRANT) begin
      if (req_ok) begin
        if (gnt_dch_q) begin
          bus.ramaddr = daddr_a[gnt_cpu_q];
          if (gnt_wr_q) begin
            bus.ramWEN   = 1'b1;
            bus.ramstore = dstore_a[gnt_cpu_q];
          end else begin
            bus.ramREN = 1'b1;
          end
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = iaddr_a[gnt_cpu_q];
        end
      end
      if (bus.ramstate == RAM_ACCESS) begin
        if (gnt_dch_q) begin
          bus.dwait[gnt_cpu_q] = 1'b0;
        end else begin
          bus.iwait[gnt_cpu_q] = 1'b0;
        end
      end
    end
  end

  assign bus.iload    = {CPUS{bus.ramload}};
  assign bus.dload    = {CPUS{bus.ramload}};
  assign bus.err      = err_q;
  assign bus.done_cnt = done_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_cpu_q <= '0;
      gnt_dch_q <= 1'b0;
      gnt_wr_q  <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_cpu_q <= gnt_cpu_d;
      gnt_dch_q <= gnt_dch_d;
      gnt_wr_q  <= gnt_wr_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end
endmodule
`default_nettype wire
